// File: rtl/alu_seq_ctrl.sv
// Single-issue sequencer driving one register-bank read, ALU evaluation and write-back per command.
// Optional DIV_ZERO_TRAP_EN adds a sticky div_zero output that suppresses divide-by-zero write-back.
module alu_seq_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_rs1,
  input  logic [ADDR_W-1:0] cmd_rs2,
  input  logic [ADDR_W-1:0] cmd_rd,
  output logic [ADDR_W-1:0] rf_rd_addr1,
  output logic [ADDR_W-1:0] rf_rd_addr2,
  input  logic [DATA_W-1:0] rf_rd_data1,
  input  logic [DATA_W-1:0] rf_rd_data2,
  output logic              rf_wr_en,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_r,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              illegal_op,
`ifdef DIV_ZERO_TRAP_EN
  output logic              div_zero,
`endif
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

  state_t            state;
  logic [3:0]        op_q;
  logic [ADDR_W-1:0] rd_q;
  logic              unary;
  logic              illegal;
  logic              trap;

  assign unary   = (op_q == 4'd7) || (op_q == 4'd11) || (op_q == 4'd12) || (op_q == 4'd13);
  assign illegal = (op_q >= 4'd14);

`ifdef DIV_ZERO_TRAP_EN
  assign trap = (alu_op == 4'd3) && (alu_b == '0);
`else
  assign trap = 1'b0;
`endif

  // Source addresses are registered at accept so the bank sees them for the whole READ cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      op_q        <= '0;
      rd_q        <= '0;
      cmd_ready   <= 1'b1;
      rf_rd_addr1 <= '0;
      rf_rd_addr2 <= '0;
      rf_wr_en    <= 1'b0;
      rf_wr_addr  <= '0;
      rf_wr_data  <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      done        <= 1'b0;
      illegal_op  <= 1'b0;
      result      <= '0;
      retired     <= '0;
`ifdef DIV_ZERO_TRAP_EN
      div_zero    <= 1'b0;
`endif
    end else begin
      rf_wr_en   <= 1'b0;
      done       <= 1'b0;
      illegal_op <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            op_q        <= cmd_op;
            rd_q        <= cmd_rd;
            rf_rd_addr1 <= cmd_rs1;
            rf_rd_addr2 <= cmd_rs2;
            cmd_ready   <= 1'b0;
            state       <= READ;
          end
        end
        READ: begin
          alu_a  <= rf_rd_data1;
          alu_b  <= unary ? '0 : rf_rd_data2;
          alu_op <= op_q;
          state  <= EXEC;
        end
        // Write strobe, done and the retired count all become visible together in WRITE.
        EXEC: begin
          done       <= 1'b1;
          illegal_op <= illegal;
          rf_wr_addr <= rd_q;
          retired    <= retired + CNT_W'(1);
          if (!illegal && !trap) begin
            result     <= alu_r;
            rf_wr_data <= alu_r;
            rf_wr_en   <= 1'b1;
          end else begin
            rf_wr_data <= result;
          end
`ifdef DIV_ZERO_TRAP_EN
          if (trap) div_zero <= 1'b1;
`endif
          state <= WRITE;
        end
        WRITE: begin
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: behavioural bank/ALU plus a command-level reference model.
// Honours DIV_ZERO_TRAP_EN when the design is built with it.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op, cmd_rs1, cmd_rs2, cmd_rd;
  logic [3:0]  rf_rd_addr1, rf_rd_addr2, rf_wr_addr;
  logic [31:0] rf_rd_data1, rf_rd_data2, rf_wr_data;
  logic        rf_wr_en;
  logic [31:0] alu_a, alu_b, alu_r, result;
  logic [3:0]  alu_op;
  logic        done, illegal_op;
  logic [15:0] retired;
`ifdef DIV_ZERO_TRAP_EN
  logic        div_zero;
`endif

  alu_seq_ctrl #(.DATA_W(32), .ADDR_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_rd(cmd_rd),
    .rf_rd_addr1(rf_rd_addr1), .rf_rd_addr2(rf_rd_addr2),
    .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_r(alu_r),
    .done(done), .result(result), .illegal_op(illegal_op),
`ifdef DIV_ZERO_TRAP_EN
    .div_zero(div_zero),
`endif
    .retired(retired)
  );

  always #5 clk = ~clk;

  // Behavioural ALU; illegal opcodes return a marker value that must never be captured.
  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a * b;
      4'd3:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd4:  return a & b;
      4'd5:  return a | b;
      4'd6:  return a ^ b;
      4'd7:  return ~a;
      4'd8:  return a << b[4:0];
      4'd9:  return a >> b[4:0];
      4'd10: return $unsigned($signed(a) >>> b[4:0]);
      4'd11: return a + 1;
      4'd12: return a - 1;
      4'd13: return 32'($countones(a));
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic logic is_unary(input logic [3:0] op);
    return (op == 4'd7) || (op == 4'd11) || (op == 4'd12) || (op == 4'd13);
  endfunction

  logic [31:0] bank [16];
  logic        pre_en = 1'b0;
  logic [3:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;

  assign rf_rd_data1 = bank[rf_rd_addr1];
  assign rf_rd_data2 = bank[rf_rd_addr2];
  assign alu_r       = alu_f(alu_op, alu_a, alu_b);

  always @(posedge clk) begin
    if (pre_en) bank[pre_addr] <= pre_data;
    else if (rf_wr_en) bank[rf_wr_addr] <= rf_wr_data;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          edge_n;
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic        ill;
    logic [31:0] res;
    logic [15:0] ret;
    logic [31:0] b;
  } rec_t;

  rec_t obsq[$];
  rec_t expq[$];
  int   done_pulses = 0;
  int   we_pulses   = 0;

  always @(negedge clk) begin
    if (done) obsq.push_back('{cyc, rf_wr_en, rf_wr_addr, rf_wr_data, illegal_op, result, retired, alu_b});
    if (done) done_pulses <= done_pulses + 1;
    if (rf_wr_en) we_pulses <= we_pulses + 1;
  end

  // Reference model state at command granularity.
  logic [31:0] mdl [16];
  logic [31:0] m_result;
  logic [15:0] m_retired;
  logic        m_divz;
  int          m_writes;
  int          n_assert = 0;
  int          n_fail   = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=0x%h expected=0x%h", tag, obs, expv);
    end
  endtask

  task automatic preload(input logic [3:0] addr, input logic [31:0] data);
    pre_en = 1'b1; pre_addr = addr; pre_data = data;
    @(negedge clk);
    pre_en = 1'b0;
    mdl[addr] = data;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge with cmd_valid still high.
  task automatic applyStimulus(input logic [3:0] op, input logic [3:0] rs1, input logic [3:0] rs2,
                               input logic [3:0] rd, output int acc);
    rec_t        e;
    logic [31:0] a, b, v;
    logic        trap;
    int          waitc;
    a = mdl[rs1];
    b = is_unary(op) ? 32'd0 : mdl[rs2];
    v = alu_f(op, a, b);
`ifdef DIV_ZERO_TRAP_EN
    trap = (op == 4'd3) && (b == 0);
    if (trap) m_divz = 1'b1;
`else
    trap = 1'b0;
`endif
    e.we  = (op < 4'd14) && !trap;
    if (e.we) begin
      mdl[rd]  = v;
      m_result = v;
      m_writes++;
    end
    m_retired++;
    e.wa = rd; e.wd = v; e.ill = (op >= 4'd14); e.res = m_result; e.ret = m_retired; e.b = b;
    cmd_op = op; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_rd = rd; cmd_valid = 1'b1;
    waitc = 0;
    while (!cmd_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    if (waitc >= 50) checkOutput("accept_timeout", 32'd0, 32'd1);
    acc      = cyc + 1;
    e.edge_n = acc;
    expq.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    cmd_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int   w;
    rec_t e, o;
    cmd_valid = 1'b0;
    w = 0;
    while (obsq.size() < expq.size() && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (obsq.size() != expq.size()) checkOutput("drain_count", obsq.size(), expq.size());
    while (expq.size() > 0 && obsq.size() > 0) begin
      e = expq.pop_front();
      o = obsq.pop_front();
      checkOutput($sformatf("r%0d_latency", e.ret), o.edge_n - e.edge_n, 32'd2);
      checkOutput($sformatf("r%0d_wr_en", e.ret), o.we, e.we);
      if (e.we) begin
        checkOutput($sformatf("r%0d_wr_addr", e.ret), o.wa, e.wa);
        checkOutput($sformatf("r%0d_wr_data", e.ret), o.wd, e.wd);
      end
      checkOutput($sformatf("r%0d_illegal", e.ret), o.ill, e.ill);
      checkOutput($sformatf("r%0d_result", e.ret), o.res, e.res);
      checkOutput($sformatf("r%0d_retired", e.ret), o.ret, e.ret);
      checkOutput($sformatf("r%0d_alu_b", e.ret), o.b, e.b);
    end
    obsq.delete();
    expq.delete();
  endtask

  initial begin
    int          acc1, acc2, dp, wp;
    logic [31:0] saved [16];
    rst = 1'b1; cmd_valid = 1'b0;
    cmd_op = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_rd = '0;
    m_result = '0; m_retired = '0; m_divz = 1'b0; m_writes = 0;
    repeat (3) @(negedge clk);
    checkOutput("rst_cmd_ready", cmd_ready, 1);
    checkOutput("rst_wr_en", rf_wr_en, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_illegal", illegal_op, 0);
    checkOutput("rst_result", result, 0);
    checkOutput("rst_retired", retired, 0);
    checkOutput("rst_alu_a", alu_a, 0);
    checkOutput("rst_alu_b", alu_b, 0);
    checkOutput("rst_alu_op", alu_op, 0);
    checkOutput("rst_rd_addr1", rf_rd_addr1, 0);
    checkOutput("rst_rd_addr2", rf_rd_addr2, 0);
    checkOutput("rst_wr_addr", rf_wr_addr, 0);
    checkOutput("rst_wr_data", rf_wr_data, 0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) preload(4'(i), 32'd0);
    preload(4'd1, 32'h10); preload(4'd2, 32'h5); preload(4'd6, 32'hFF);
    preload(4'd7, 32'h1234); preload(4'd9, 32'hFFFF_FFFF);

    $display("[TB] directed commands");
    applyStimulus(4'd0, 4'd1, 4'd2, 4'd3, acc1);
    drain();
    applyStimulus(4'd1, 4'd1, 4'd2, 4'd4, acc1);
    applyStimulus(4'd2, 4'd1, 4'd2, 4'd5, acc2);
    checkOutput("b2b_accept_gap", acc2 - acc1, 32'd4);
    drain();
    applyStimulus(4'd13, 4'd6, 4'd7, 4'd8, acc1);
    applyStimulus(4'd7, 4'd9, 4'd2, 4'd10, acc1);
    applyStimulus(4'd14, 4'd1, 4'd2, 4'd11, acc1);
    applyStimulus(4'd0, 4'd3, 4'd3, 4'd3, acc1);
    drain();
    preload(4'd1, 32'h20);
    applyStimulus(4'd3, 4'd1, 4'd0, 4'd2, acc1);
    drain();
`ifdef DIV_ZERO_TRAP_EN
    checkOutput("div_zero_set", div_zero, 1);
`endif

    $display("[TB] reset during EXEC");
    for (int i = 0; i < 16; i++) saved[i] = mdl[i];
    dp = done_pulses; wp = we_pulses;
    applyStimulus(4'd0, 4'd1, 4'd2, 4'd12, acc1);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_cmd_ready", cmd_ready, 1);
    checkOutput("abort_retired", retired, 0);
    checkOutput("abort_result", result, 0);
    checkOutput("abort_done", done, 0);
`ifdef DIV_ZERO_TRAP_EN
    checkOutput("abort_div_zero", div_zero, 0);
`endif
    repeat (4) @(negedge clk);
    checkOutput("abort_no_done", done_pulses, dp);
    checkOutput("abort_no_write", we_pulses, wp);
    checkOutput("abort_bank", bank[12], saved[12]);
    void'(expq.pop_back());
    for (int i = 0; i < 16; i++) mdl[i] = saved[i];
    m_result = '0; m_retired = '0; m_divz = 1'b0; m_writes = we_pulses;

    $display("[TB] random commands");
    for (int i = 0; i < 16; i++)
      preload(4'(i), ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom);
    for (int n = 0; n < 40; n++) begin
      applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), acc1);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    drain();
    for (int i = 0; i < 16; i++) checkOutput($sformatf("bank_r%0d", i), bank[i], mdl[i]);
    checkOutput("write_pulses", we_pulses, m_writes);
`ifdef DIV_ZERO_TRAP_EN
    checkOutput("div_zero_final", div_zero, m_divz);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Single-issue sequencer that executes register-to-register ALU commands against the register bank.
- Per command: reads two source registers, drives the 32-bit ALU (4-bit op encoding 0-13), captures the result and writes it back to the destination register.
- Sits between a command source (testbench or decoder) and the existing register bank + ALU pair.
- Owns all bank read/write sequencing; exactly one command in flight at any time.

Parameters:
DATA_W, 32, datapath width; matches ALU operand/result width
ADDR_W, 4, register-bank address width (16 registers)
CNT_W, 16, width of retired-command counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command
cmd_op  input  4  ALU op: 0 add, 1 sub, 2 mul, 3 div, 4 and, 5 or, 6 xor, 7 not, 8 shl, 9 shr, 10 sra, 11 inc, 12 dec, 13 hamming weight
cmd_rs1  input  ADDR_W  source register A
cmd_rs2  input  ADDR_W  source register B
cmd_rd  input  ADDR_W  destination register
rf_rd_addr1  output  ADDR_W  bank read port 1 address
rf_rd_addr2  output  ADDR_W  bank read port 2 address
rf_rd_data1  input  DATA_W  bank read data 1 (combinational, same cycle as address)
rf_rd_data2  input  DATA_W  bank read data 2
rf_wr_en  output  1  bank write strobe
rf_wr_addr  output  ADDR_W  bank write address
rf_wr_data  output  DATA_W  bank write data
alu_a  output  DATA_W  ALU operand a
alu_b  output  DATA_W  ALU operand b
alu_op  output  4  ALU opcode
alu_r  input  DATA_W  ALU result (combinational)
done  output  1  one-cycle pulse on command completion
result  output  DATA_W  last captured ALU result
illegal_op  output  1  one-cycle pulse with done when cmd_op is 14 or 15
retired  output  CNT_W  count of completed commands

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: state IDLE; cmd_ready=1; rf_wr_en=0; done=0; illegal_op=0; result=0; retired=0; alu_a=alu_b=0; alu_op=0; rf_rd_addr*=0; rf_wr_addr=0; rf_wr_data=0.
- FSM states: IDLE -> READ -> EXEC -> WRITE -> IDLE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch op/rs1/rs2/rd and go to READ.
  - cmd_ready=0 in every other state.
- READ:
  - rf_rd_addr1=rs1, rf_rd_addr2=rs2.
  - Register rf_rd_data1 into alu_a.
  - Register rf_rd_data2 into alu_b, except ops 7, 11, 12, 13 (unary), where alu_b<=0.
  - alu_op<=op. Go to EXEC.
- EXEC: ALU inputs stable; capture alu_r into result. Go to WRITE.
- WRITE:
  - rf_wr_en=1 for exactly one cycle; rf_wr_addr=rd; rf_wr_data=result.
  - done=1 for one cycle; retired increments, wrapping at 2^CNT_W-1 -> 0.
  - Go to IDLE.
- Latency: command accepted at edge N; write and done in cycle N+3; cmd_ready high again in cycle N+4. Max throughput: one command per 4 cycles.
- cmd_valid held high continuously: next command accepted in the first IDLE cycle, with no bubble beyond IDLE.
- Illegal op (14, 15):
  - Still passes READ and EXEC.
  - In WRITE: rf_wr_en=0, result unchanged, done=1, illegal_op=1, retired increments.
- rd equal to rs1 or rs2: legal. Sources are read in READ, before the write.
- Reset asserted in any state: next edge returns to IDLE with all outputs at reset values. The in-flight command is discarded with no write.
- Command inputs are ignored outside IDLE.
- alu_a/alu_b/alu_op hold their values outside READ (no glitching to 0).

Optional Feature:
DIV_ZERO_TRAP_EN
- Defined: op 3 with alu_b==0 in EXEC sets a sticky div_zero output (extra 1-bit port). In WRITE, rf_wr_en=0 and result is unchanged; done still pulses and retired increments. div_zero clears only on rst.
- Undefined: no div_zero port; divide-by-zero writes whatever alu_r returns.

Test Plan:
- R1=0x10, R2=0x5, cmd add rd=3 -> rf_wr_en in cycle N+3, rf_wr_addr=3, rf_wr_data=0x15, done pulse, retired=1.
- Back-to-back, cmd_valid high: sub R1,R2->R4 then mul R1,R2->R5 -> writes 0xB then 0x50; second accept at N+4; writes 4 cycles apart.
- R6=0xFF, op 13, rs2=7 -> alu_b=0, R6 write... rd=8 receives 0x8; op 7 on R9=0xFFFFFFFF -> 0x0.
- op 14 -> done and illegal_op together, no rf_wr_en, result unchanged, retired increments.
- rst asserted during EXEC -> no rf_wr_en, no done, cmd_ready=1 next cycle, retired=0.
- DIV_ZERO_TRAP_EN defined: R1=0x20, R0=0, div rd=2 -> no write, div_zero=1 held until rst. Undefined: write occurs.
